// File: rtl/uart_rx_mv.sv
// uart_rx_mv: oversampled UART receiver with 3-sample majority vote, runtime parity/stop
// selection and a valid/ready holding register. Define UART_RX_BREAK_DET_EN for break detection.
module uart_rx_mv #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned OVERSAMPLE  = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx,
    input  logic                  sample_tick,
    input  logic [1:0]            parity_mode,
    input  logic                  two_stop,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  parity_error,
    output logic                  framing_error,
    output logic                  overrun_error,
    output logic                  busy,
    output logic                  break_det
);
    localparam int unsigned CW = $clog2(OVERSAMPLE);
    localparam int unsigned BW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] MID_LO   = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] MID      = CW'(OVERSAMPLE / 2);
    localparam logic [CW-1:0] MID_HI   = CW'(OVERSAMPLE / 2 + 1);
    localparam logic [CW-1:0] LAST     = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);
`ifdef UART_RX_BREAK_DET_EN
    localparam bit BREAK_EN = 1'b1;
`else
    localparam bit BREAK_EN = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;

    state_t                  state_q, state_d;
    logic [SYNC_STAGES-1:0]  sync_q, sync_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [BW-1:0]           bit_idx_q, bit_idx_d;
    logic                    stop_idx_q, stop_idx_d;
    logic                    v0_q, v0_d, v1_q, v1_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic                    par_err_q, par_err_d;
    logic                    zero_q, zero_d;
    logic                    stop_err_q, stop_err_d;
    logic                    par_en_q, par_en_d, par_odd_q, par_odd_d;
    logic                    cfg_two_stop_q, cfg_two_stop_d;
    logic [DATA_WIDTH-1:0]   rx_data_q, rx_data_d;
    logic                    rx_valid_q, rx_valid_d;
    logic                    pe_q, pe_d, fe_q, fe_d, ov_q, ov_d;
    logic                    break_det_q, break_det_d;
    logic                    rx_s, vote, commit, commit_fe, break_hit;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], rx};
        rx_s   = sync_q[SYNC_STAGES-1];
        vote   = (v0_q & v1_q) | (v0_q & rx_s) | (v1_q & rx_s);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= IDLE;
            sync_q         <= '1;
            cnt_q          <= '0;
            bit_idx_q      <= '0;
            stop_idx_q     <= 1'b0;
            v0_q           <= 1'b1;
            v1_q           <= 1'b1;
            shift_q        <= '0;
            par_err_q      <= 1'b0;
            zero_q         <= 1'b0;
            stop_err_q     <= 1'b0;
            par_en_q       <= 1'b0;
            par_odd_q      <= 1'b0;
            cfg_two_stop_q <= 1'b0;
            rx_data_q      <= '0;
            rx_valid_q     <= 1'b0;
            pe_q           <= 1'b0;
            fe_q           <= 1'b0;
            ov_q           <= 1'b0;
            break_det_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            sync_q         <= sync_d;
            cnt_q          <= cnt_d;
            bit_idx_q      <= bit_idx_d;
            stop_idx_q     <= stop_idx_d;
            v0_q           <= v0_d;
            v1_q           <= v1_d;
            shift_q        <= shift_d;
            par_err_q      <= par_err_d;
            zero_q         <= zero_d;
            stop_err_q     <= stop_err_d;
            par_en_q       <= par_en_d;
            par_odd_q      <= par_odd_d;
            cfg_two_stop_q <= cfg_two_stop_d;
            rx_data_q      <= rx_data_d;
            rx_valid_q     <= rx_valid_d;
            pe_q           <= pe_d;
            fe_q           <= fe_d;
            ov_q           <= ov_d;
            break_det_q    <= break_det_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        bit_idx_d      = bit_idx_q;
        stop_idx_d     = stop_idx_q;
        v0_d           = v0_q;
        v1_d           = v1_q;
        shift_d        = shift_q;
        par_err_d      = par_err_q;
        zero_d         = zero_q;
        stop_err_d     = stop_err_q;
        par_en_d       = par_en_q;
        par_odd_d      = par_odd_q;
        cfg_two_stop_d = cfg_two_stop_q;
        commit         = 1'b0;
        commit_fe      = 1'b0;
        break_hit      = 1'b0;
        if (sample_tick) begin
            if (state_q != IDLE) begin
                cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
                if (cnt_q == MID_LO) v0_d = rx_s;
                if (cnt_q == MID)    v1_d = rx_s;
            end
            unique case (state_q)
                IDLE: if (!rx_s) begin
                    state_d        = START;
                    cnt_d          = '0;
                    bit_idx_d      = '0;
                    stop_idx_d     = 1'b0;
                    par_err_d      = 1'b0;
                    stop_err_d     = 1'b0;
                    zero_d         = 1'b1;
                    par_en_d       = (parity_mode == 2'b01) || (parity_mode == 2'b10);
                    par_odd_d      = (parity_mode == 2'b10);
                    cfg_two_stop_d = two_stop;
                end
                START: begin
                    if (cnt_q == MID_HI && vote) state_d = IDLE;
                    else if (cnt_q == LAST)      state_d = DATA;
                end
                DATA: begin
                    if (cnt_q == MID_HI) begin
                        shift_d = {vote, shift_q[DATA_WIDTH-1:1]};
                        zero_d  = zero_q & ~vote;
                    end
                    if (cnt_q == LAST) begin
                        if (bit_idx_q == LAST_BIT) state_d = par_en_q ? PARITY : STOP;
                        else                       bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
                PARITY: begin
                    if (cnt_q == MID_HI) begin
                        par_err_d = (^{shift_q, vote}) ^ par_odd_q;
                        zero_d    = zero_q & ~vote;
                    end
                    if (cnt_q == LAST) state_d = STOP;
                end
                STOP: begin
                    // Last stop bit commits at its vote; the rest of the bit is not waited out.
                    if (cnt_q == MID_HI) begin
                        stop_err_d = stop_err_q | ~vote;
                        if (BREAK_EN && !stop_idx_q && zero_q && !vote) begin
                            break_hit = 1'b1;
                            state_d   = WAIT_HIGH;
                        end else if (stop_idx_q || !cfg_two_stop_q) begin
                            commit    = 1'b1;
                            commit_fe = stop_err_q | ~vote;
                            state_d   = (stop_err_q || !vote) ? WAIT_HIGH : IDLE;
                        end
                    end else if (cnt_q == LAST) begin
                        stop_idx_d = 1'b1;
                    end
                end
                WAIT_HIGH: if (rx_s) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        pe_d        = pe_q;
        fe_d        = fe_q;
        ov_d        = ov_q;
        break_det_d = break_hit;
        if (commit) begin
            if (!rx_valid_q || rx_ready) begin
                rx_data_d  = shift_q;
                pe_d       = par_err_q;
                fe_d       = commit_fe;
                rx_valid_d = 1'b1;
                ov_d       = 1'b0;
            end else begin
                ov_d = 1'b1;
            end
        end else if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
            pe_d       = 1'b0;
            fe_d       = 1'b0;
            ov_d       = 1'b0;
        end
    end

    assign rx_data       = rx_data_q;
    assign rx_valid      = rx_valid_q;
    assign parity_error  = pe_q;
    assign framing_error = fe_q;
    assign overrun_error = ov_q;
    assign busy          = (state_q != IDLE);
    assign break_det     = break_det_q;
endmodule

// File: tb/tb_uart_rx_mv.sv
// Randomized self-checking bench for uart_rx_mv: frames are built from bit lists and the
// expected word/status comes from a holding-register model of the consumer side.
`timescale 1ns/1ps
module tb_uart_rx_mv;
    localparam int unsigned OS = 16;
`ifdef UART_RX_BREAK_DET_EN
    localparam bit BRK_EN = 1'b1;
`else
    localparam bit BRK_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst, rx, sample_tick, two_stop, rx_ready;
    logic [1:0] parity_mode;
    logic [7:0] rx_data;
    logic       rx_valid, parity_error, framing_error, overrun_error, busy, break_det;
    int unsigned div_cnt = 0;

    int unsigned n_checks = 0, n_pass = 0;
    logic       m_valid, m_pe, m_fe, m_ov;
    logic [7:0] m_data;

    int unsigned mon_valid = 0, mon_brk = 0, mon_acc = 0;
    logic [7:0]  cap_data;
    logic        cap_pe, cap_fe, cap_ov;

    uart_rx_mv #(.DATA_WIDTH(8), .OVERSAMPLE(OS), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .rx(rx), .sample_tick(sample_tick),
        .parity_mode(parity_mode), .two_stop(two_stop),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .parity_error(parity_error), .framing_error(framing_error),
        .overrun_error(overrun_error), .busy(busy), .break_det(break_det)
    );

    always #5 clk = ~clk;
    always @(posedge clk) div_cnt <= (div_cnt == 2) ? 0 : div_cnt + 1;
    assign sample_tick = (div_cnt == 2);

    always @(negedge clk) begin
        if (rx_valid) mon_valid++;
        if (break_det) mon_brk++;
        if (rx_valid && rx_ready) begin
            mon_acc++;
            cap_data = rx_data;
            cap_pe   = parity_error;
            cap_fe   = framing_error;
            cap_ov   = overrun_error;
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic wait_ticks(input int unsigned n);
        repeat (n) @(posedge clk iff sample_tick);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        wait_ticks(OS);
    endtask

    task automatic check_hold(input string tag);
        chk({tag, "_valid"}, rx_valid, m_valid);
        if (m_valid) chk({tag, "_data"}, rx_data, m_data);
        chk({tag, "_pe"}, parity_error, m_pe);
        chk({tag, "_fe"}, framing_error, m_fe);
        chk({tag, "_ov"}, overrun_error, m_ov);
    endtask

    task automatic do_accept();
        check_hold("pre_acc");
        @(negedge clk) rx_ready = 1'b1;
        @(negedge clk) rx_ready = 1'b0;
        m_valid = 1'b0; m_pe = 1'b0; m_fe = 1'b0; m_ov = 1'b0;
        check_hold("post_acc");
    endtask

    task automatic send_frame(input logic [7:0] d, input logic [1:0] pm, input logic ts,
                              input logic pflip, input logic s1, input logic s2,
                              input int unsigned hold, input logic stream);
        logic par_on, p, exp_pe, exp_fe, exp_brk, last_low;
        int unsigned v0, b0, a0;
        par_on   = (pm == 2'b01) || (pm == 2'b10);
        p        = (^d) ^ (pm == 2'b10) ^ pflip;
        exp_pe   = par_on && pflip;
        exp_fe   = !s1 || (ts && !s2);
        exp_brk  = BRK_EN && (d == 8'h00) && (!par_on || !p) && !s1;
        last_low = ts ? !s2 : !s1;
        wait_ticks(1);
        parity_mode = pm;
        two_stop    = ts;
        rx_ready    = stream;
        v0 = mon_valid; b0 = mon_brk; a0 = mon_acc;
        drive_bit(1'b0);
        // configuration inputs must be ignored once the frame has started
        parity_mode = 2'($urandom);
        two_stop    = 1'($urandom);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (par_on) drive_bit(p);
        drive_bit(s1);
        if (ts) drive_bit(s2);
        if (last_low) begin
            wait_ticks(hold);
            chk("wait_high_busy", busy, 1);
        end
        rx = 1'b1;
        wait_ticks(4 + $urandom_range(0, 16));
        chk("idle_busy", busy, 0);
        chk("break_pulses", mon_brk - b0, exp_brk);
        if (stream) begin
            rx_ready = 1'b0;
            chk("stream_valid_cycles", mon_valid - v0, !exp_brk);
            chk("stream_accepts", mon_acc - a0, !exp_brk);
            if (!exp_brk) begin
                chk("stream_data", cap_data, d);
                chk("stream_pe", cap_pe, exp_pe);
                chk("stream_fe", cap_fe, exp_fe);
                chk("stream_ov", cap_ov, 0);
            end
            check_hold("stream");
        end else begin
            if (!exp_brk) begin
                if (!m_valid) begin
                    m_valid = 1'b1; m_data = d; m_pe = exp_pe; m_fe = exp_fe;
                end else begin
                    m_ov = 1'b1;
                end
            end
            check_hold("hold");
        end
    endtask

    task automatic glitch(input int unsigned len);
        wait_ticks(1);
        rx = 1'b0;
        wait_ticks(len);
        rx = 1'b1;
        wait_ticks(3 * OS);
        chk("false_start_busy", busy, 0);
        check_hold("false_start");
    endtask

    task automatic reset_mid_frame();
        wait_ticks(1);
        rx = 1'b0;
        wait_ticks(OS);
        rx = 1'b1;
        wait_ticks(3 * OS);
        chk("mid_frame_busy", busy, 1);
        @(negedge clk) rst = 1'b0;
        @(negedge clk) rst = 1'b1;
        m_valid = 1'b0; m_pe = 1'b0; m_fe = 1'b0; m_ov = 1'b0;
        chk("mid_rst_busy", busy, 0);
        check_hold("mid_rst");
        wait_ticks(12 * OS);
        chk("mid_rst_no_commit", rx_valid, 0);
    endtask

    initial begin
        logic [7:0]  d;
        logic        stream;
        rst = 1'b0; rx = 1'b1; rx_ready = 1'b0; parity_mode = 2'b00; two_stop = 1'b0;
        m_valid = 1'b0; m_pe = 1'b0; m_fe = 1'b0; m_ov = 1'b0; m_data = 8'h00;
        repeat (4) @(posedge clk);
        #1;
        chk("rst_data", rx_data, 0);
        chk("rst_valid", rx_valid, 0);
        chk("rst_pe", parity_error, 0);
        chk("rst_fe", framing_error, 0);
        chk("rst_ov", overrun_error, 0);
        chk("rst_busy", busy, 0);
        chk("rst_break", break_det, 0);
        @(negedge clk) rst = 1'b1;
        wait_ticks(4);

        send_frame(8'hA5, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b1);
        send_frame(8'h03, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1, 0, 1'b1);
        send_frame(8'h03, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b1);
        send_frame(8'h5C, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 30, 1'b1);
        glitch(4);
        send_frame(8'h11, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b0);
        send_frame(8'h22, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b0);
        do_accept();
        send_frame(8'h00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 2 * OS, 1'b0);
        if (m_valid) do_accept();

        for (int i = 0; i < 30; i++) begin
            stream = ($urandom_range(0, 2) == 0);
            if (m_valid && (stream || $urandom_range(0, 1) == 1)) do_accept();
            if ($urandom_range(0, 7) == 0) glitch($urandom_range(1, 6));
            d = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            send_frame(d, 2'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0),
                       ($urandom_range(0, 5) != 0), ($urandom_range(0, 5) != 0),
                       ($urandom_range(0, 1) == 1) ? $urandom_range(0, 40) : 0, stream);
        end

        reset_mid_frame();
        send_frame(8'h3C, 2'b01, 1'b1, 1'b0, 1'b1, 1'b1, 0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
